fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
// - Pointer/flag controller for the FIFO; drives w_en/w_addr/r_addr of fifo_register_file.
// - Converts push/pop requests into guarded memory writes and head-of-queue reads.
// - Produces full/empty flags and overflow/underflow error pulses.
// - Read is first-word-fall-through: r_data from the register file is valid whenever empty==0.
// PARAMETERS
// - ADDR_WIDTH  3  address bits; FIFO depth = 2**ADDR_WIDTH; must match fifo_register_file
// PORTS
// - clk        in   1           single clock, all state updates on posedge
// - rst_n      in   1           synchronous reset, active-low
// - wr         in   1           push request; data is presented on fifo_register_file.w_data
// - rd         in   1           pop request; consumes the current head entry
// - w_en       out  1           memory write enable = wr & accepted (combinational)
// - w_addr     out  ADDR_WIDTH  write pointer (registered)
// - r_addr     out  ADDR_WIDTH  read pointer / head address (registered)
// - full       out  1           registered; 2**ADDR_WIDTH entries held
// - empty      out  1           registered; 0 entries held
// - wr_err     out  1           1-cycle pulse: push rejected (registered)
// - rd_err     out  1           1-cycle pulse: pop rejected (registered)
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): w_addr=0, r_addr=0, full=0, empty=1, wr_err=0, rd_err=0.
//   Reset wins over any wr/rd in the same cycle; mid-operation reset discards all entries.
// - Storage is one register file; no data path inside this block.
// - Acceptance, evaluated on current registered flags:
//   push_ok = wr & (~full | rd);  pop_ok = rd & ~empty.
// - w_en = push_ok (combinational, same cycle); the memory write lands on the same edge.
// - Pointers: w_addr += push_ok, r_addr += pop_ok, modulo 2**ADDR_WIDTH (natural wrap).
// - Flag update per edge, by case:
//   - push_ok & ~pop_ok: empty<=0; full<=(w_addr+1 == r_addr).
//   - pop_ok & ~push_ok: full<=0;  empty<=(r_addr+1 == w_addr).
//   - push_ok & pop_ok:  flags unchanged; occupancy unchanged.
//   - neither: all state holds.
// - Boundary cases:
//   - full & wr & rd: both accepted; the old head is read combinationally before the edge
//     and overwritten at the edge; full stays 1.
//   - empty & wr & rd: push accepted, pop rejected; empty<=0; rd_err<=1.
//   - full & wr & ~rd: push rejected; w_en=0; wr_err<=1.
//   - empty & rd & ~wr: pop rejected; rd_err<=1.
//   - wr_err/rd_err clear on the next edge unless re-triggered.
//   - full and empty are never 1 together.
// - Latency:
//   - a word pushed at edge N is visible on r_data after edge N (empty falls at N);
//   - a pop at edge N advances r_addr at N.
// CONFIGURATION
// - FIFO_CTRL_LEVEL_EN defined:
//   - adds output level [ADDR_WIDTH:0]: occupancy 0..2**ADDR_WIDTH, reset 0;
//     +1 on push-only, -1 on pop-only, unchanged otherwise.
//   - adds output almost_full = (level >= 2**ADDR_WIDTH-1), combinational from level.
//   - adds output almost_empty = (level <= 1), combinational from level.
// - FIFO_CTRL_LEVEL_EN undefined: these ports and the counter do not exist;
//   all other behaviour is identical.
// TESTING
// - Reset with wr=rd=1 held -> after edge: w_addr=0, r_addr=0, empty=1, full=0, no err pulse.
// - 8 pushes (D0..D7), no pops -> full=1 after 8th edge, w_addr=0; 9th wr -> w_en=0, wr_err pulse, w_addr stays 0.
// - From full, 8 pops -> r_data order D0..D7; empty=1 after 8th edge; 9th rd -> rd_err pulse, r_addr stays 0.
// - Empty, wr=rd=1 with data 0xA5 -> push accepted, rd_err=1, empty=0, r_data=0xA5 next cycle.
// - Full, wr=rd=1 for 3 cycles -> full stays 1, both pointers advance by 3, no err pulses.
// - Wrap: 5 push, 5 pop, 6 push -> w_addr=3, r_addr=5; with FIFO_CTRL_LEVEL_EN: level=6, almost_full=0, almost_empty=0.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: push/pop handshake and pointer/flag bundle (level outputs under FIFO_CTRL_LEVEL_EN)
interface fifo_ctrl_if #(parameter int ADDR_WIDTH = 3);
   logic                  wr, rd, w_en, full, empty, wr_err, rd_err;
   logic [ADDR_WIDTH-1:0] w_addr, r_addr;
`ifdef FIFO_CTRL_LEVEL_EN
   logic [ADDR_WIDTH:0]   level;
   logic                  almost_full, almost_empty;
   modport master(output wr, rd,
                  input w_en, w_addr, r_addr, full, empty, wr_err, rd_err, level, almost_full, almost_empty);
   modport slave(input wr, rd,
                 output w_en, w_addr, r_addr, full, empty, wr_err, rd_err, level, almost_full, almost_empty);
`else
   modport master(output wr, rd,
                  input w_en, w_addr, r_addr, full, empty, wr_err, rd_err);
   modport slave(input wr, rd,
                 output w_en, w_addr, r_addr, full, empty, wr_err, rd_err);
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FWFT FIFO pointer/flag controller; optional occupancy outputs under FIFO_CTRL_LEVEL_EN
module fifo_ctrl #(parameter int ADDR_WIDTH = 3) (
   input logic       clk,
   input logic       rst_n,
   fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0] ONE = 1;
   logic push_ok, pop_ok;
   // a full FIFO still takes a push when the head is popped on the same edge
   assign push_ok  = bus.wr & (~bus.full | bus.rd);
   assign pop_ok   = bus.rd & ~bus.empty;
   assign bus.w_en = push_ok;
   // pointers, flags and error pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.w_addr <= '0;
         bus.r_addr <= '0;
         bus.full   <= 1'b0;
         bus.empty  <= 1'b1;
         bus.wr_err <= 1'b0;
         bus.rd_err <= 1'b0;
      end else begin
         bus.w_addr <= push_ok ? bus.w_addr + ONE : bus.w_addr;
         bus.r_addr <= pop_ok ? bus.r_addr + ONE : bus.r_addr;
         bus.wr_err <= bus.wr & ~push_ok;
         bus.rd_err <= bus.rd & ~pop_ok;
         if (push_ok & ~pop_ok) begin
            bus.empty <= 1'b0;
            bus.full  <= (bus.w_addr + ONE) == bus.r_addr;
         end else if (pop_ok & ~push_ok) begin
            bus.full  <= 1'b0;
            bus.empty <= (bus.r_addr + ONE) == bus.w_addr;
         end
      end
   end
`ifdef FIFO_CTRL_LEVEL_EN
   localparam logic [ADDR_WIDTH:0] ONE_L = 1;
   localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
   // occupancy counter tracks net push/pop
   always_ff @(posedge clk) begin
      if (!rst_n)
         bus.level <= '0;
      else if (push_ok & ~pop_ok)
         bus.level <= bus.level + ONE_L;
      else if (pop_ok & ~push_ok)
         bus.level <= bus.level - ONE_L;
   end
   assign bus.almost_full  = bus.level >= AF_TH;
   assign bus.almost_empty = bus.level <= ONE_L;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed + random check of fifo_ctrl against a queue model with a stand-in register file
module tb_fifo_ctrl;
   localparam int AW = 3;
   localparam int DEPTH = 1 << AW;
   logic clk = 0, rst_n = 0;
   logic [7:0] wdata = 0;
   logic [7:0] mem [DEPTH];
   logic [7:0] r_data;
   int vectors = 0, errors = 0;
   bit started = 0;
   byte unsigned q[$];
   int m_wc = 0, m_rc = 0;
   bit m_wr_err = 0, m_rd_err = 0;

   fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus();
   fifo_ctrl #(.ADDR_WIDTH(AW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // stand-in for fifo_register_file: write on edge, combinational head read
   always @(posedge clk) if (bus.w_en) mem[bus.w_addr] <= wdata;
   assign r_data = mem[bus.r_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: queue of held words, push/pop counters
   always @(posedge clk) begin
      bit push, pop;
      started = 1;
      push = bus.wr && (q.size() != DEPTH || bus.rd);
      pop  = bus.rd && q.size() != 0;
      if (!rst_n) begin
         q.delete();
         m_wc = 0; m_rc = 0; m_wr_err = 0; m_rd_err = 0;
      end else begin
         m_wr_err = bus.wr && !push;
         m_rd_err = bus.rd && !pop;
         if (pop) begin void'(q.pop_front()); m_rc++; end
         if (push) begin q.push_back(wdata); m_wc++; end
      end
   end

   // compare all outputs against the model mid-cycle
   always @(negedge clk) if (started) begin
      chk("w_en", bus.w_en, bus.wr && (q.size() != DEPTH || bus.rd));
      chk("w_addr", bus.w_addr, m_wc % DEPTH);
      chk("r_addr", bus.r_addr, m_rc % DEPTH);
      chk("full", bus.full, q.size() == DEPTH);
      chk("empty", bus.empty, q.size() == 0);
      chk("wr_err", bus.wr_err, m_wr_err);
      chk("rd_err", bus.rd_err, m_rd_err);
      if (q.size() != 0) chk("r_data", r_data, q[0]);
`ifdef FIFO_CTRL_LEVEL_EN
      chk("level", bus.level, q.size());
      chk("almost_full", bus.almost_full, q.size() >= DEPTH - 1);
      chk("almost_empty", bus.almost_empty, q.size() <= 1);
`endif
   end

   task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit rn);
      bus.wr = w; bus.rd = r; wdata = d; rst_n = rn;
      @(posedge clk); #1;
   endtask

   initial begin
      bus.wr = 1; bus.rd = 1;
      #1;
      cyc(1, 1, 8'h00, 0);
      cyc(1, 1, 8'h00, 0);
      chk("rst w_addr", bus.w_addr, 0);
      chk("rst r_addr", bus.r_addr, 0);
      chk("rst empty", bus.empty, 1);
      chk("rst full", bus.full, 0);
      chk("rst errs", {bus.wr_err, bus.rd_err}, 0);
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'h10 + 8'(i), 1);
      chk("fill full", bus.full, 1);
      chk("fill w_addr", bus.w_addr, 0);
      bus.wr = 1; bus.rd = 0; #1;
      chk("over w_en", bus.w_en, 0);
      @(posedge clk); #1;
      chk("over wr_err", bus.wr_err, 1);
      chk("over w_addr", bus.w_addr, 0);
      cyc(0, 0, 8'h00, 1);
      chk("wr_err clears", bus.wr_err, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain order", r_data, 8'h10 + 8'(i));
         cyc(0, 1, 8'h00, 1);
      end
      chk("drain empty", bus.empty, 1);
      cyc(0, 1, 8'h00, 1);
      chk("under rd_err", bus.rd_err, 1);
      chk("under r_addr", bus.r_addr, 0);
      cyc(1, 1, 8'hA5, 1);
      chk("A5 rd_err", bus.rd_err, 1);
      chk("A5 empty", bus.empty, 0);
      chk("A5 r_data", r_data, 8'hA5);
      cyc(0, 1, 8'h00, 1);
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'h30 + 8'(i), 1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 8'h50 + 8'(i), 1);
      chk("rw full", bus.full, 1);
      chk("rw w_addr", bus.w_addr, 4);
      chk("rw r_addr", bus.r_addr, 4);
      chk("rw errs", {bus.wr_err, bus.rd_err}, 0);
      chk("rw head", r_data, 8'h33);
      cyc(0, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'h60 + 8'(i), 1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 1);
      for (int i = 0; i < 6; i++) cyc(1, 0, 8'h70 + 8'(i), 1);
      chk("wrap w_addr", bus.w_addr, 3);
      chk("wrap r_addr", bus.r_addr, 5);
`ifdef FIFO_CTRL_LEVEL_EN
      chk("wrap level", bus.level, 6);
      chk("wrap almost_full", bus.almost_full, 0);
      chk("wrap almost_empty", bus.almost_empty, 0);
`endif
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 63) != 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
